// File: rtl/seq_register_execute_skid_pkg.sv
// Shared types and default widths for the execute-to-writeback skid stage register.
package seq_register_execute_skid_pkg;

    localparam int unsigned DefDataSize  = 32;
    localparam int unsigned DefInstrSize = 16;
    localparam int unsigned DefDestSize  = 3;

    // Encoding equals the occupancy reported on o_count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_stage_entry.sv
// One payload slot of the stage register: loads on demand, otherwise holds, cleared by reset.
module seq_stage_entry #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned INSTR_SIZE = 16,
    parameter int unsigned DEST_SIZE  = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [INSTR_SIZE-1:0]       d_instruction,
    input  logic                        d_data_source,
    input  logic [DEST_SIZE-1:0]        d_destination,
    input  logic signed [DATA_SIZE-1:0] d_result,
    input  logic                        d_register_file_write,
    output logic [INSTR_SIZE-1:0]       q_instruction,
    output logic                        q_data_source,
    output logic [DEST_SIZE-1:0]        q_destination,
    output logic signed [DATA_SIZE-1:0] q_result,
    output logic                        q_register_file_write
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_instruction         <= '0;
            q_data_source         <= 1'b0;
            q_destination         <= '0;
            q_result              <= '0;
            q_register_file_write <= 1'b0;
        end else if (load) begin
            q_instruction         <= d_instruction;
            q_data_source         <= d_data_source;
            q_destination         <= d_destination;
            q_result              <= d_result;
            q_register_file_write <= d_register_file_write;
        end
    end

endmodule

// File: rtl/seq_register_execute_skid.sv
// EXECUTE->WRITEBACK stage register with valid/ready handshake, one-entry skid buffer,
// flush, global halt and a forwarding view of the head entry.
module seq_register_execute_skid
    import seq_register_execute_skid_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = DefDataSize,
    parameter int unsigned INSTR_SIZE = DefInstrSize,
    parameter int unsigned DEST_SIZE  = DefDestSize
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_sys_halt,
    input  logic                        i_flush,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [INSTR_SIZE-1:0]       i_instruction,
    input  logic                        i_data_source,
    input  logic [DEST_SIZE-1:0]        i_destination,
    input  logic signed [DATA_SIZE-1:0] i_result,
    input  logic                        i_register_file_write,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [INSTR_SIZE-1:0]       o_instruction,
    output logic                        o_data_source,
    output logic [DEST_SIZE-1:0]        o_destination,
    output logic signed [DATA_SIZE-1:0] o_result,
    output logic                        o_register_file_write,
    output logic [1:0]                  o_count,
    output logic                        o_fwd_valid,
    output logic [DEST_SIZE-1:0]        o_fwd_destination,
    output logic signed [DATA_SIZE-1:0] o_fwd_result
);

    state_e state_q, state_d;

    logic head_valid, skid_valid;
    logic accept, release_head;
    logic head_load, skid_load;

    logic [INSTR_SIZE-1:0]       head_instruction, skid_instruction, head_in_instruction;
    logic                        head_data_source, skid_data_source, head_in_data_source;
    logic [DEST_SIZE-1:0]        head_destination, skid_destination, head_in_destination;
    logic signed [DATA_SIZE-1:0] head_result, skid_result, head_in_result;
    logic                        head_rf_write, skid_rf_write, head_in_rf_write;

    assign head_valid   = (state_q != StEmpty);
    assign skid_valid   = (state_q == StFull);
    assign o_ready      = ~skid_valid;
    assign accept       = i_valid & o_ready & ~i_sys_halt;
    assign release_head = head_valid & i_ready & ~i_sys_halt;

    // Head refills from the skid slot when it holds data, otherwise from the input.
    assign head_load = ~i_flush & ((accept & (~head_valid | release_head)) |
                                   (skid_valid & release_head));
    assign skid_load = ~i_flush & accept & head_valid & ~release_head;

    assign head_in_instruction = skid_valid ? skid_instruction : i_instruction;
    assign head_in_data_source = skid_valid ? skid_data_source : i_data_source;
    assign head_in_destination = skid_valid ? skid_destination : i_destination;
    assign head_in_result      = skid_valid ? skid_result      : i_result;
    assign head_in_rf_write    = skid_valid ? skid_rf_write    : i_register_file_write;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = StEmpty;
        end else if (!i_sys_halt) begin
            unique case (state_q)
                StEmpty: if (accept) state_d = StOne;
                StOne: begin
                    if (accept && !release_head) begin
                        state_d = StFull;
                    end else if (!accept && release_head) begin
                        state_d = StEmpty;
                    end
                end
                StFull:  if (release_head) state_d = StOne;
                default: state_d = StEmpty;
            endcase
        end
    end

    seq_stage_entry #(
        .DATA_SIZE  (DATA_SIZE),
        .INSTR_SIZE (INSTR_SIZE),
        .DEST_SIZE  (DEST_SIZE)
    ) u_head (
        .clk                   (i_clk),
        .rst_n                 (i_rst_n),
        .load                  (head_load),
        .d_instruction         (head_in_instruction),
        .d_data_source         (head_in_data_source),
        .d_destination         (head_in_destination),
        .d_result              (head_in_result),
        .d_register_file_write (head_in_rf_write),
        .q_instruction         (head_instruction),
        .q_data_source         (head_data_source),
        .q_destination         (head_destination),
        .q_result              (head_result),
        .q_register_file_write (head_rf_write)
    );

    seq_stage_entry #(
        .DATA_SIZE  (DATA_SIZE),
        .INSTR_SIZE (INSTR_SIZE),
        .DEST_SIZE  (DEST_SIZE)
    ) u_skid (
        .clk                   (i_clk),
        .rst_n                 (i_rst_n),
        .load                  (skid_load),
        .d_instruction         (i_instruction),
        .d_data_source         (i_data_source),
        .d_destination         (i_destination),
        .d_result              (i_result),
        .d_register_file_write (i_register_file_write),
        .q_instruction         (skid_instruction),
        .q_data_source         (skid_data_source),
        .q_destination         (skid_destination),
        .q_result              (skid_result),
        .q_register_file_write (skid_rf_write)
    );

    assign o_valid               = head_valid;
    assign o_instruction         = head_instruction;
    assign o_data_source         = head_data_source;
    assign o_destination         = head_destination;
    assign o_result              = head_result;
    assign o_register_file_write = head_rf_write & head_valid;
    assign o_count               = state_q;
    assign o_fwd_valid           = head_rf_write & head_valid & ~head_data_source;
    assign o_fwd_destination     = head_destination;
    assign o_fwd_result          = head_result;

endmodule

// File: tb/tb_seq_register_execute_skid.sv
// Scoreboard bench for seq_register_execute_skid: accepted beats are queued and matched
// against released beats, plus directed checks of occupancy, halt, flush, reset and forwarding.
module tb_seq_register_execute_skid;

    typedef struct packed {
        logic [15:0] instr;
        logic        ds;
        logic [2:0]  dst;
        logic [31:0] res;
        logic        rfw;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_sys_halt, i_flush, i_valid, i_ready;
    logic               o_ready, o_valid;
    logic [15:0]        i_instruction, o_instruction;
    logic               i_data_source, o_data_source;
    logic [2:0]         i_destination, o_destination, o_fwd_destination;
    logic signed [31:0] i_result, o_result, o_fwd_result;
    logic               i_register_file_write, o_register_file_write;
    logic [1:0]         o_count;
    logic               o_fwd_valid;

    int    n_cmp = 0;
    int    n_err = 0;
    int    n_pop = 0;
    beat_t sb[$];

    always #5 clk = ~clk;

    seq_register_execute_skid u_dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_sys_halt            (i_sys_halt),
        .i_flush               (i_flush),
        .i_valid               (i_valid),
        .o_ready               (o_ready),
        .i_instruction         (i_instruction),
        .i_data_source         (i_data_source),
        .i_destination         (i_destination),
        .i_result              (i_result),
        .i_register_file_write (i_register_file_write),
        .o_valid               (o_valid),
        .i_ready               (i_ready),
        .o_instruction         (o_instruction),
        .o_data_source         (o_data_source),
        .o_destination         (o_destination),
        .o_result              (o_result),
        .o_register_file_write (o_register_file_write),
        .o_count               (o_count),
        .o_fwd_valid           (o_fwd_valid),
        .o_fwd_destination     (o_fwd_destination),
        .o_fwd_result          (o_fwd_result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [31:0] r);
        beat_t b;
        b.instr = 16'h1000 | {8'h00, r[7:0]};
        b.ds    = r[1];
        b.dst   = r[2:0];
        b.res   = r;
        b.rfw   = r[0];
        return b;
    endfunction

    task automatic drive(input beat_t b);
        i_instruction         = b.instr;
        i_data_source         = b.ds;
        i_destination         = b.dst;
        i_result              = b.res;
        i_register_file_write = b.rfw;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Presents a beat and holds it until the handshake completes.
    task automatic offer(input beat_t b);
        logic fired;
        fired   = 1'b0;
        i_valid = 1'b1;
        drive(b);
        for (int i = 0; i < 50 && !fired; i++) begin
            @(negedge clk);
            fired = o_ready && !i_sys_halt && !i_flush;
            step();
        end
        i_valid = 1'b0;
        if (!fired) check("offer_timeout", 32'(fired), 32'd1);
    endtask

    task automatic flush_cycle();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
    endtask

    // Scoreboard monitor: pop on release, push on accept, drop everything on flush/reset.
    initial begin
        beat_t exp_b, cur;
        forever begin
            @(negedge clk);
            if (!rst_n || i_flush) begin
                sb.delete();
            end else begin
                if (o_valid && i_ready && !i_sys_halt) begin
                    if (sb.size() == 0) begin
                        check("sb_spurious", 32'(o_valid), 32'd0);
                    end else begin
                        exp_b = sb.pop_front();
                        n_pop++;
                        check("sb_result", o_result, exp_b.res);
                        check("sb_instr", 32'(o_instruction), 32'(exp_b.instr));
                        check("sb_dest", 32'(o_destination), 32'(exp_b.dst));
                        check("sb_rfw", 32'(o_register_file_write), 32'(exp_b.rfw));
                    end
                end
                if (i_valid && o_ready && !i_sys_halt) begin
                    cur = '{instr: i_instruction, ds: i_data_source, dst: i_destination,
                            res: i_result, rfw: i_register_file_write};
                    sb.push_back(cur);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        i_sys_halt = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        drive(mk(32'd0));
        #12;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_fwd_valid", 32'(o_fwd_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Back-to-back stream with the consumer always ready.
        i_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            offer(mk(32'(k)));
            check("stream_count", 32'(o_count), 32'd1);
            check("stream_head", o_result, 32'(k));
        end
        idle(3);
        check("stream_pops", 32'(n_pop), 32'd8);

        // Backpressure: one extra beat absorbed into the skid, then o_ready drops.
        i_ready = 1'b0;
        offer(mk(32'h10));
        offer(mk(32'h11));
        i_valid = 1'b1;
        drive(mk(32'h12));
        @(negedge clk);
        check("skid_ready", 32'(o_ready), 32'd0);
        check("skid_count", 32'(o_count), 32'd2);
        check("skid_head", o_result, 32'h10);
        step();
        i_ready = 1'b1;
        offer(mk(32'h12));
        idle(4);
        check("skid_drained", 32'(sb.size()), 32'd0);

        // Halt while full: state freezes even though both handshakes are offered.
        i_ready = 1'b0;
        offer(mk(32'h20));
        offer(mk(32'h21));
        i_sys_halt = 1'b1;
        i_ready = 1'b1;
        i_valid = 1'b1;
        drive(mk(32'h22));
        repeat (5) begin
            @(negedge clk);
            check("halt_count", 32'(o_count), 32'd2);
            check("halt_head", o_result, 32'h20);
            step();
        end
        i_sys_halt = 1'b0;
        offer(mk(32'h22));
        idle(4);
        check("halt_drained", 32'(sb.size()), 32'd0);

        // Flush while full with a beat offered.
        i_ready = 1'b0;
        offer(mk(32'h30));
        offer(mk(32'h31));
        i_valid = 1'b1;
        drive(mk(32'h99));
        flush_cycle();
        i_valid = 1'b0;
        check("flush_count", 32'(o_count), 32'd0);
        check("flush_rfw", 32'(o_register_file_write), 32'd0);
        check("flush_fwd", 32'(o_fwd_valid), 32'd0);
        check("flush_ready", 32'(o_ready), 32'd1);
        i_ready = 1'b1;
        idle(3);

        // Flush with one held and an otherwise-acceptable beat offered.
        i_ready = 1'b0;
        offer(mk(32'h40));
        i_valid = 1'b1;
        drive(mk(32'h41));
        flush_cycle();
        i_valid = 1'b0;
        check("flush1_count", 32'(o_count), 32'd0);
        i_ready = 1'b1;
        idle(3);

        // Forwarding view of the head.
        i_ready = 1'b0;
        offer('{instr: 16'hABCD, ds: 1'b0, dst: 3'd5, res: -32'sd7, rfw: 1'b1});
        check("fwd_valid", 32'(o_fwd_valid), 32'd1);
        check("fwd_dest", 32'(o_fwd_destination), 32'd5);
        check("fwd_result", o_fwd_result, -32'sd7);
        check("fwd_rfw", 32'(o_register_file_write), 32'd1);
        flush_cycle();
        offer('{instr: 16'hABCD, ds: 1'b1, dst: 3'd5, res: -32'sd7, rfw: 1'b1});
        check("fwd_ds1_valid", 32'(o_fwd_valid), 32'd0);
        check("fwd_ds1_src", 32'(o_data_source), 32'd1);
        flush_cycle();

        // Asynchronous reset while full.
        offer(mk(32'h53));
        offer(mk(32'h57));
        check("pre_rst_count", 32'(o_count), 32'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_count", 32'(o_count), 32'd0);
        check("arst_ready", 32'(o_ready), 32'd1);
        check("arst_result", o_result, 32'd0);
        check("arst_instr", 32'(o_instruction), 32'd0);
        check("arst_dest", 32'(o_destination), 32'd0);
        check("arst_rfw", 32'(o_register_file_write), 32'd0);
        check("arst_fwd_result", o_fwd_result, 32'd0);
        step();
        rst_n = 1'b1;
        i_ready = 1'b1;
        idle(3);
        check("final_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
